stream_accumulator: RTL and testbench

- Sequential front-end for the N-bit ripple-carry adder `full_adder_16b`.
- Accepts a packet of unsigned N-bit operands over a valid/ready stream and folds each beat into a running sum through the adder.
- Presents the packet total, a sticky overflow flag and a beat count on a valid/ready output stream.
- Sits between an operand source (e.g. a memory reader) and result consumers.

---
 rtl/stream_accumulator_pkg.sv | 6 +
 rtl/full_adder_16b.sv | 17 +
 rtl/stream_accumulator.sv | 57 +++++
 tb/tb_stream_accumulator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_accumulator_pkg.sv
// stream_accumulator_pkg: shared state encoding and default widths
package stream_accumulator_pkg;
    typedef enum logic {ST_ACCUM = 1'b0, ST_OUTPUT = 1'b1} state_t;
    localparam int N_DEFAULT = 16;
    localparam int CNT_W_DEFAULT = 8;
endpackage

// File: rtl/full_adder_16b.sv
// full_adder_16b: N-bit ripple-carry adder with carry-in tied to 0
module full_adder_16b #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         carry
);
    logic [N:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign carry = c[N];
endmodule

// File: rtl/stream_accumulator.sv
// stream_accumulator: folds a valid/ready packet of operands into a sum with sticky overflow and saturating beat count
module stream_accumulator
    import stream_accumulator_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);
    state_t state, state_nxt;
    logic [N-1:0] acc, sum;
    logic [CNT_W-1:0] cnt;
    logic ovf, carry, accept, done;
    assign accept = in_valid & in_ready;
    assign done = out_valid & out_ready;
    full_adder_16b #(.N(N)) u_add (
        .a(acc),
        .b(in_data),
        .sum(sum),
        .carry(carry)
    );
    always_ff @(posedge clk) begin
        state <= rst ? ST_ACCUM : state_nxt;
    end
    always_comb begin
        state_nxt = state == ST_ACCUM ? ((accept & in_last) ? ST_OUTPUT : ST_ACCUM)
                                      : (out_ready ? ST_ACCUM : ST_OUTPUT);
    end
    always_comb begin
        in_ready  = state == ST_ACCUM;
        out_valid = state == ST_OUTPUT;
        out_sum   = acc;
        out_ovf   = ovf;
        out_count = cnt;
    end
    always_ff @(posedge clk) begin
        if (rst || done) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            ovf <= ovf | carry;
            cnt <= (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_stream_accumulator.sv
// tb_stream_accumulator: scoreboard bench driving a default and a CNT_W=2 accumulator in lockstep
module tb_stream_accumulator;
    typedef struct {
        logic [15:0] sum;
        logic        ovf;
        logic [7:0]  c8;
        logic [1:0]  c2;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic in_ready, out_valid, out_ovf, in_ready2, out_valid2, out_ovf2;
    logic [15:0] out_sum, out_sum2;
    logic [7:0] out_count;
    logic [1:0] out_count2;
    int checks = 0, errors = 0;
    exp_t sb[$];
    logic [15:0] m_acc = '0;
    logic m_ovf = 1'b0;
    logic [7:0] m_c8 = '0;
    logic [1:0] m_c2 = '0;

    stream_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .out_count(out_count)
    );
    stream_accumulator #(.N(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
        .out_ovf(out_ovf2), .out_count(out_count2)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        m_acc = '0;
        m_ovf = 1'b0;
        m_c8 = '0;
        m_c2 = '0;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted with in_valid still high.
    task automatic send(input logic [15:0] d, input logic last);
        logic [16:0] s;
        int t = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        while (!(in_ready && in_ready2) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) begin
            checks++;
            errors++;
            $display("FAIL send_ready: in_ready=%b/%b required 1 within 20 cycles", in_ready, in_ready2);
        end
        @(posedge clk);
        s = {1'b0, m_acc} + {1'b0, d};
        m_acc = s[15:0];
        m_ovf = m_ovf | s[16];
        m_c8 = (m_c8 == 8'hFF) ? m_c8 : m_c8 + 8'd1;
        m_c2 = (m_c2 == 2'd3) ? m_c2 : m_c2 + 2'd1;
        if (last) begin
            sb.push_back('{sum: m_acc, ovf: m_ovf, c8: m_c8, c2: m_c2});
            model_clear();
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_count} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0}) begin
            errors++;
            $display("FAIL reset: got rdy=%b v=%b sum=%h ovf=%b cnt=%0d required rdy=1 v=0 sum=0 ovf=0 cnt=0",
                     in_ready, out_valid, out_sum, out_ovf, out_count);
        end
        model_clear();
    endtask

    task automatic test_single();
        exp_t e;
        out_ready = 1'b1;
        send(16'h1234, 1'b1);
        idle(0);
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_count, out_valid2, out_count2} !== {1'b1, e.sum, e.ovf, e.c8, 1'b1, e.c2}) begin
            errors++;
            $display("FAIL single: got v=%b sum=%h ovf=%b cnt=%0d cnt2=%0d required v=1 sum=%h ovf=%b cnt=%0d cnt2=%0d",
                     out_valid, out_sum, out_ovf, out_count, out_count2, e.sum, e.ovf, e.c8, e.c2);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL single_return: got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_gaps();
        exp_t e;
        out_ready = 1'b1;
        send(16'h0001, 1'b0);
        idle(3);
        send(16'h0002, 1'b0);
        idle(2);
        checks++;
        if ({out_valid, out_sum} !== {1'b0, 16'h0003}) begin
            errors++;
            $display("FAIL gaps_mid: got v=%b acc=%h required v=0 acc=0003", out_valid, out_sum);
        end
        out_ready = 1'b0;
        send(16'h0003, 1'b1);
        idle(0);
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_count, out_count2} !== {1'b1, e.sum, e.ovf, e.c8, e.c2}) begin
            errors++;
            $display("FAIL gaps: got v=%b sum=%h ovf=%b cnt=%0d cnt2=%0d required v=1 sum=%h ovf=%b cnt=%0d cnt2=%0d",
                     out_valid, out_sum, out_ovf, out_count, out_count2, e.sum, e.ovf, e.c8, e.c2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        exp_t e;
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0001, 1'b1);
        idle(0);
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_count, out_ovf2} !== {1'b1, e.sum, e.ovf, e.c8, e.ovf}) begin
            errors++;
            $display("FAIL overflow: got v=%b sum=%h ovf=%b/%b cnt=%0d required v=1 sum=%h ovf=%b cnt=%0d",
                     out_valid, out_sum, out_ovf, out_ovf2, out_count, e.sum, e.ovf, e.c8);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        send(16'h0100, 1'b0);
        send(16'h0023, 1'b1);
        in_data = 16'hFFFF;
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({in_ready, in_ready2, out_valid, out_sum, out_ovf, out_count} !== {2'b00, 1'b1, e.sum, e.ovf, e.c8}) begin
                errors++;
                $display("FAIL backpressure[%0d]: got rdy=%b/%b v=%b sum=%h ovf=%b cnt=%0d required rdy=0 v=1 sum=%h ovf=%b cnt=%0d",
                         i, in_ready, in_ready2, out_valid, out_sum, out_ovf, out_count, e.sum, e.ovf, e.c8);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_sum, out_count} !== {2'b10, 16'h0, 8'h0}) begin
            errors++;
            $display("FAIL backpressure_release: got rdy=%b v=%b sum=%h cnt=%0d required rdy=1 v=0 sum=0 cnt=0",
                     in_ready, out_valid, out_sum, out_count);
        end
        send(16'h0007, 1'b1);
        idle(0);
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_count} !== {1'b1, e.sum, e.ovf, e.c8}) begin
            errors++;
            $display("FAIL backpressure_next: got v=%b sum=%h ovf=%b cnt=%0d required v=1 sum=%h ovf=%b cnt=%0d",
                     out_valid, out_sum, out_ovf, out_count, e.sum, e.ovf, e.c8);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int i = 0; i < 6; i++) send(16'h0001, i == 5);
        idle(0);
        e = sb.pop_front();
        checks++;
        if ({out_valid2, out_sum2, out_count2, out_count} !== {1'b1, e.sum, e.c2, e.c8}) begin
            errors++;
            $display("FAIL saturation: got v2=%b sum2=%h cnt2=%0d cnt=%0d required v2=1 sum2=%h cnt2=%0d cnt=%0d",
                     out_valid2, out_sum2, out_count2, out_count, e.sum, e.c2, e.c8);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        exp_t e;
        send(16'h0010, 1'b0);
        send(16'h0020, 1'b0);
        idle(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        send(16'h0005, 1'b1);
        idle(0);
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_count} !== {1'b1, e.sum, e.ovf, e.c8}) begin
            errors++;
            $display("FAIL reset_mid: got v=%b sum=%h ovf=%b cnt=%0d required v=1 sum=%h ovf=%b cnt=%0d",
                     out_valid, out_sum, out_ovf, out_count, e.sum, e.ovf, e.c8);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, out_sum} !== {2'b01, 16'h0}) begin
            errors++;
            $display("FAIL reset_drop: got v=%b rdy=%b sum=%h required v=0 rdy=1 sum=0", out_valid, in_ready, out_sum);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_gaps();
        test_overflow();
        test_backpressure();
        test_saturation();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
